// File: rtl/synth_voice_pkg.sv
// Shared types and constants for the voice allocator and its age tracker.
package synth_voice_pkg;

   typedef enum logic [1:0] {
      NOTE_ON  = 2'd0,
      NOTE_OFF = 2'd1,
      CTRL     = 2'd2
   } ev_type_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_COMMIT = 2'd2,
      ST_SWEEP  = 2'd3
   } va_state_t;

   localparam logic [6:0] CC_SUSTAIN       = 7'd64;
   localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
   localparam logic [7:0] KEY_NONE         = 8'hFF;

   // Voice event payload sent to synth_engine (slot index travels separately
   // because its width depends on the VOICES parameter).
   typedef struct packed {
      logic [7:0] key;
      logic [6:0] vel;
      logic       gate;
      logic       steal;
   } vo_event_t;

   // MIDI keys are 7 bits; stored keys are 8 bits so KEY_NONE never matches.
   function automatic logic [7:0] key_of(input logic [6:0] k);
      return {1'b0, k};
   endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Per-slot saturating age counters; reports the oldest gated slot.
module voice_age_tracker
   import synth_voice_pkg::*;
#(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = $clog2(VOICES),
   parameter int AGE_W   = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_bump,
   input  logic [V_WIDTH-1:0] i_slot,
   input  logic [VOICES-1:0]  i_gated,
   output logic [V_WIDTH-1:0] o_oldest,
   output logic               o_any
);

   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   logic [VOICES-1:0][AGE_W-1:0] r_age;
   logic [AGE_W-1:0]             w_best;

   // A new gate-on makes its slot youngest and ages every other gated slot.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_age <= '0;
      end else if (i_bump) begin
         for (int i = 0; i < VOICES; i++) begin
            if (V_WIDTH'(i) == i_slot)
               r_age[i] <= '0;
            else if (i_gated[i] && (r_age[i] != AGE_MAX))
               r_age[i] <= r_age[i] + AGE_W'(1);
         end
      end
   end

   // Oldest gated slot; strict compare keeps the lowest index on ties.
   always_comb begin
      o_any    = 1'b0;
      o_oldest = '0;
      w_best   = '0;
      for (int i = 0; i < VOICES; i++) begin
         if (i_gated[i] && (!o_any || (r_age[i] > w_best))) begin
            o_any    = 1'b1;
            w_best   = r_age[i];
            o_oldest = V_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: MIDI channel events in, per-slot gate events out.
module voice_allocator
   import synth_voice_pkg::*;
#(
   parameter int VOICES  = 8,
   parameter int V_WIDTH = $clog2(VOICES),
   parameter int AGE_W   = 8
) (
   input  logic               reg_clk,
   input  logic               reset_reg,
   input  logic [3:0]         cfg_chan,
   input  logic               cfg_omni,
   input  logic [VOICES-1:0]  voice_free,
   input  logic               ev_valid,
   output logic               ev_ready,
   input  ev_type_t           ev_type,
   input  logic [3:0]         ev_chan,
   input  logic [6:0]         ev_data1,
   input  logic [6:0]         ev_data2,
   output logic               vo_valid,
   output logic [V_WIDTH-1:0] vo_slot,
   output logic [7:0]         vo_key,
   output logic [6:0]         vo_vel,
   output logic               vo_gate,
   output logic               vo_steal,
   output logic [VOICES-1:0]  keys_on,
   output logic [V_WIDTH:0]   active_keys
);

   localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);
   localparam logic [V_WIDTH:0]   ONE_CNT  = (V_WIDTH+1)'(1);

   va_state_t                 r_state, w_state_nxt;
   logic [V_WIDTH-1:0]        r_idx;
   logic [6:0]                r_key, r_vel;
   logic                      r_on;
   logic                      r_match_hit, r_free_hit;
   logic [V_WIDTH-1:0]        r_match_slot, r_free_slot;
   logic                      r_sus_pedal, r_sweep_all;
   logic [VOICES-1:0]         r_sustained, r_keys_on;
   logic [VOICES-1:0][7:0]    r_key_val;
   logic [V_WIDTH:0]          r_active;
   logic                      r_vo_valid;
   logic [V_WIDTH-1:0]        r_vo_slot;
   vo_event_t                 r_vo;

   logic                      w_chan_ok, w_is_on, w_is_off, w_pedal_rel, w_all_off;
   logic                      w_last, w_any_gated, w_steal, w_tgt_gated, w_sw_hit, w_bump;
   logic [V_WIDTH-1:0]        w_oldest, w_tgt_slot;

   assign w_chan_ok   = cfg_omni || (ev_chan == cfg_chan);
   assign w_is_on     = (ev_type == NOTE_ON) && (ev_data2 != 7'd0);
   assign w_is_off    = (ev_type == NOTE_OFF) || ((ev_type == NOTE_ON) && (ev_data2 == 7'd0));
   assign w_pedal_rel = (ev_type == CTRL) && (ev_data1 == CC_SUSTAIN) && (ev_data2 < 7'd64) && r_sus_pedal;
   assign w_all_off   = (ev_type == CTRL) && (ev_data1 == CC_ALL_NOTES_OFF);
   assign w_last      = (r_idx == LAST_IDX);

   // Slot choice: retrigger, then free slot, then steal the oldest held slot.
   // With nothing free and nothing held (all slots releasing) slot 0 is reused
   // without counting as a steal.
   assign w_steal     = r_on && !r_match_hit && !r_free_hit && w_any_gated;
   assign w_tgt_slot  = r_match_hit ? r_match_slot :
                        r_free_hit  ? r_free_slot  :
                        w_any_gated ? w_oldest     : '0;
   assign w_tgt_gated = r_keys_on[w_tgt_slot];
   assign w_sw_hit    = r_keys_on[r_idx] && (r_sweep_all || r_sustained[r_idx]);
   assign w_bump      = (r_state == ST_COMMIT) && r_on;

   voice_age_tracker #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .AGE_W(AGE_W)) u_age (
      .i_clk    (reg_clk),
      .i_rst    (reset_reg),
      .i_bump   (w_bump),
      .i_slot   (w_tgt_slot),
      .i_gated  (r_keys_on),
      .o_oldest (w_oldest),
      .o_any    (w_any_gated)
   );

   // State register.
   always_ff @(posedge reg_clk) begin
      if (reset_reg) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   // Next-state and handshake; filtered or single-cycle events stay in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      ev_ready    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ev_ready = 1'b1;
            if (ev_valid && w_chan_ok) begin
               if (w_is_on || w_is_off)         w_state_nxt = ST_SCAN;
               else if (w_pedal_rel || w_all_off) w_state_nxt = ST_SWEEP;
            end
         end
         ST_SCAN:   if (w_last) w_state_nxt = ST_COMMIT;
         ST_COMMIT: w_state_nxt = ST_IDLE;
         ST_SWEEP:  if (w_last) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Event latch, slot scan, commit and sweep datapath.
   always_ff @(posedge reg_clk) begin
      if (reset_reg) begin
         r_idx        <= '0;
         r_key        <= '0;
         r_vel        <= '0;
         r_on         <= 1'b0;
         r_match_hit  <= 1'b0;
         r_free_hit   <= 1'b0;
         r_match_slot <= '0;
         r_free_slot  <= '0;
         r_sus_pedal  <= 1'b0;
         r_sweep_all  <= 1'b0;
         r_sustained  <= '0;
         r_keys_on    <= '0;
         r_key_val    <= {VOICES{KEY_NONE}};
         r_active     <= '0;
         r_vo_valid   <= 1'b0;
         r_vo_slot    <= '0;
         r_vo         <= '0;
      end else begin
         r_vo_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (ev_valid && w_chan_ok) begin
                  r_key       <= ev_data1;
                  r_vel       <= ev_data2;
                  r_on        <= w_is_on;
                  r_idx       <= '0;
                  r_match_hit <= 1'b0;
                  r_free_hit  <= 1'b0;
                  if (ev_type == CTRL && ev_data1 == CC_SUSTAIN) begin
                     if (ev_data2 >= 7'd64) begin
                        r_sus_pedal <= 1'b1;
                     end else if (r_sus_pedal) begin
                        r_sus_pedal <= 1'b0;
                        r_sweep_all <= 1'b0;
                     end
                  end else if (w_all_off) begin
                     r_sus_pedal <= 1'b0;
                     r_sustained <= '0;
                     r_sweep_all <= 1'b1;
                  end
               end
            end
            ST_SCAN: begin
               if (!w_last) r_idx <= r_idx + V_WIDTH'(1);
               if (!r_match_hit && (r_key_val[r_idx] == key_of(r_key))) begin
                  r_match_hit  <= 1'b1;
                  r_match_slot <= r_idx;
               end
               if (!r_free_hit && voice_free[r_idx] && !r_keys_on[r_idx]) begin
                  r_free_hit  <= 1'b1;
                  r_free_slot <= r_idx;
               end
            end
            ST_COMMIT: begin
               if (r_on) begin
                  r_key_val[w_tgt_slot]   <= key_of(r_key);
                  r_keys_on[w_tgt_slot]   <= 1'b1;
                  r_sustained[w_tgt_slot] <= 1'b0;
                  if (!w_tgt_gated) r_active <= r_active + ONE_CNT;
                  r_vo_valid <= 1'b1;
                  r_vo_slot  <= w_tgt_slot;
                  r_vo       <= '{key: key_of(r_key), vel: r_vel, gate: 1'b1, steal: w_steal};
               end else if (r_match_hit) begin
                  if (r_sus_pedal) begin
                     r_sustained[r_match_slot] <= 1'b1;
                  end else begin
                     r_keys_on[r_match_slot]   <= 1'b0;
                     r_key_val[r_match_slot]   <= KEY_NONE;
                     r_sustained[r_match_slot] <= 1'b0;
                     if (r_keys_on[r_match_slot]) r_active <= r_active - ONE_CNT;
                     r_vo_valid <= 1'b1;
                     r_vo_slot  <= r_match_slot;
                     r_vo       <= '{key: KEY_NONE, vel: r_vel, gate: 1'b0, steal: 1'b0};
                  end
               end
            end
            ST_SWEEP: begin
               if (!w_last) r_idx <= r_idx + V_WIDTH'(1);
               r_sustained[r_idx] <= 1'b0;
               if (w_sw_hit) begin
                  r_keys_on[r_idx] <= 1'b0;
                  r_key_val[r_idx] <= KEY_NONE;
                  r_active         <= r_active - ONE_CNT;
                  r_vo_valid       <= 1'b1;
                  r_vo_slot        <= r_idx;
                  r_vo             <= '{key: KEY_NONE, vel: 7'd0, gate: 1'b0, steal: 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   assign vo_valid    = r_vo_valid;
   assign vo_slot     = r_vo_slot;
   assign vo_key      = r_vo.key;
   assign vo_vel      = r_vo.vel;
   assign vo_gate     = r_vo.gate;
   assign vo_steal    = r_vo.steal;
   assign keys_on     = r_keys_on;
   assign active_keys = r_active;

endmodule
